credit_sender: RTL and testbench

Transmit-side endpoint of the team's credit-based link. It accepts words on a valid/ready upstream port and forwards each one as a single-cycle registered beat on a `tx_valid`/`tx_data` link that has no ready signal. A word is forwarded only when a credit is held. Credits are granted by the receiving FIFO: one per `credit_return` pulse, each pulse meaning one entry freed. The block sits between a producer and the far-end credit FIFO.

---
 rtl/credit_sender.sv | 125 ++++++++++++
 tb/tb_credit_sender.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_sender.sv
// credit_sender
//   Transmit endpoint of the credit-based link. Upstream words arrive on a
//   valid/ready port. Each accepted word is forwarded as a single-cycle
//   registered beat on tx_valid/tx_data, but only while a credit is held.
//   The far-end FIFO returns one credit per credit_return pulse.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   link_en        enables transmission; deassertion starts a drain
//   in_valid/in_ready/in_data   upstream handshake
//   tx_valid/tx_data            link beat (no back-pressure)
//   credit_return  one-cycle pulse, one credit returned
//   credits_avail  current credit count
//   link_idle      high in IDLE
//   err_overflow   sticky credit-overflow flag
//
// Configuration
//   CREDIT_SENDER_OVF_CHECK_EN : when defined, err_overflow sets on the first
//   return that arrives with the count already full. When undefined it is
//   tied low. Saturation happens in both builds.
//
// state  | meaning
// IDLE   | link down, credits full, waiting for link_en
// ACTIVE | forwarding words while credits are held
// DRAIN  | link_en dropped, waiting for all credits to come back
module credit_sender #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_CREDITS = 8,
  localparam int CW         = $clog2(MAX_CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  link_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  credit_return,
  output logic [CW-1:0]         credits_avail,
  output logic                  link_idle,
  output logic                  err_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAX_C = CW'(MAX_CREDITS);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           credits_q, credits_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    send;

  // Ready comes from registered state only, never from in_valid.
  assign in_ready = (state_q == ST_ACTIVE) && (credits_q != '0);
  assign send     = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    credits_d  = credits_q;
    tx_valid_d = send;
    tx_data_d  = tx_data_q;

    case (state_q)
      ST_IDLE:   if (link_en)            state_d = ST_ACTIVE;
      ST_ACTIVE: if (!link_en)           state_d = ST_DRAIN;
      ST_DRAIN:  if (credits_q == MAX_C) state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase

    // A return and a send in the same cycle cancel out.
    if (credit_return && !send) begin
      if (credits_q != MAX_C) credits_d = credits_q + ONE_C;
    end else if (send && !credit_return) begin
      credits_d = credits_q - ONE_C;
    end

    if (send) tx_data_d = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      credits_q  <= MAX_C;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

`ifdef CREDIT_SENDER_OVF_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (credit_return && !send && (credits_q == MAX_C)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_overflow = err_q;
`else
  assign err_overflow = 1'b0;
`endif

  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign credits_avail = credits_q;
  assign link_idle     = (state_q == ST_IDLE);

endmodule

// File: tb/tb_credit_sender.sv
// Directed testbench for credit_sender (DATA_WIDTH=32, MAX_CREDITS=8).
// Inputs change 1 ns after the rising edge and outputs are sampled there too.
module tb_credit_sender;

  localparam int DW = 32;
  localparam int CW = 4;
`ifdef CREDIT_SENDER_OVF_CHECK_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          link_en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          credit_return;
  logic [CW-1:0] credits_avail;
  logic          link_idle;
  logic          err_overflow;

  int checks = 0;
  int errors = 0;

  credit_sender #(.DATA_WIDTH(DW), .MAX_CREDITS(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .link_en       (link_en),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .credit_return (credit_return),
    .credits_avail (credits_avail),
    .link_idle     (link_idle),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; link_en = 1'b0; in_valid = 1'b0; in_data = '0; credit_return = 1'b0;
    #12;
    rst_n = 1'b1;
    step();
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx: tx_valid=%b tx_data=%h in_ready=%b expected 0 0 0", tx_valid, tx_data, in_ready);
    end
    checks++;
    if (credits_avail !== 4'd8 || link_idle !== 1'b1 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: credits=%0d idle=%b err=%b expected 8 1 0", credits_avail, link_idle, err_overflow);
    end
  endtask

  // link_en at cycle 2, ten words offered, only eight credits.
  task automatic test_fill();
    step();
    link_en = 1'b1;
    step();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = DW'(i);
      step();
      checks++;
      if (tx_valid !== (i < 8)) begin
        errors++;
        $display("FAIL fill_valid[%0d]: got %b expected %b", i, tx_valid, (i < 8));
      end
      if (i < 8) begin
        checks++;
        if (tx_data !== DW'(i)) begin
          errors++;
          $display("FAIL fill_data[%0d]: got %h expected %h", i, tx_data, DW'(i));
        end
      end
    end
    checks++;
    if (credits_avail !== 4'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_end: credits=%0d in_ready=%b expected 0 0", credits_avail, in_ready);
    end
    checks++;
    if (tx_data !== DW'(7)) begin
      errors++;
      $display("FAIL fill_hold: tx_data=%h expected %h", tx_data, DW'(7));
    end
  endtask

  task automatic test_zero_credit_return();
    in_data = 32'h0000_00a5;
    credit_return = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zc_ready_t: in_ready=%b expected 0", in_ready);
    end
    step();
    credit_return = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || credits_avail !== 4'd1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL zc_ready_t1: in_ready=%b credits=%0d tx_valid=%b expected 1 1 0", in_ready, credits_avail, tx_valid);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 32'h0000_00a5 || credits_avail !== 4'd0) begin
      errors++;
      $display("FAIL zc_beat_t2: tx_valid=%b tx_data=%h credits=%0d expected 1 a5 0", tx_valid, tx_data, credits_avail);
    end
  endtask

  task automatic test_send_and_return();
    credit_return = 1'b1;
    repeat (3) step();
    checks++;
    if (credits_avail !== 4'd3) begin
      errors++;
      $display("FAIL sr_setup: credits=%0d expected 3", credits_avail);
    end
    in_valid = 1'b1; in_data = 32'h0000_0033;
    step();
    in_valid = 1'b0; credit_return = 1'b0;
    checks++;
    if (credits_avail !== 4'd3 || tx_valid !== 1'b1 || tx_data !== 32'h0000_0033) begin
      errors++;
      $display("FAIL sr_same_cycle: credits=%0d tx_valid=%b tx_data=%h expected 3 1 33", credits_avail, tx_valid, tx_data);
    end
    step();
    checks++;
    if (tx_valid !== 1'b0 || credits_avail !== 4'd3) begin
      errors++;
      $display("FAIL sr_single_beat: tx_valid=%b credits=%0d expected 0 3", tx_valid, credits_avail);
    end
  endtask

  task automatic test_drain();
    link_en = 1'b0;
    step();
    in_valid = 1'b1; in_data = 32'h0000_00dd;
    checks++;
    if (in_ready !== 1'b0 || link_idle !== 1'b0) begin
      errors++;
      $display("FAIL drain_enter: in_ready=%b idle=%b expected 0 0", in_ready, link_idle);
    end
    for (int k = 0; k < 5; k++) begin
      credit_return = 1'b1;
      if (k == 2) link_en = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b0 || tx_valid !== 1'b0 || link_idle !== 1'b0 || credits_avail !== CW'(4 + k)) begin
        errors++;
        $display("FAIL drain_ret[%0d]: in_ready=%b tx_valid=%b idle=%b credits=%0d expected 0 0 0 %0d",
                 k, in_ready, tx_valid, link_idle, credits_avail, 4 + k);
      end
    end
    credit_return = 1'b0; link_en = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if (link_idle !== 1'b1 || in_ready !== 1'b0 || credits_avail !== 4'd8) begin
      errors++;
      $display("FAIL drain_idle: idle=%b in_ready=%b credits=%0d expected 1 0 8", link_idle, in_ready, credits_avail);
    end
  endtask

  task automatic test_overflow();
    checks++;
    if (err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_before: err=%b expected 0", err_overflow);
    end
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    checks++;
    if (credits_avail !== 4'd8 || err_overflow !== OVF_EN) begin
      errors++;
      $display("FAIL ovf_set: credits=%0d err=%b expected 8 %b", credits_avail, err_overflow, OVF_EN);
    end
    repeat (3) step();
    checks++;
    if (credits_avail !== 4'd8 || err_overflow !== OVF_EN) begin
      errors++;
      $display("FAIL ovf_sticky: credits=%0d err=%b expected 8 %b", credits_avail, err_overflow, OVF_EN);
    end
  endtask

  task automatic test_reset_mid_send();
    link_en = 1'b1;
    step();
    in_valid = 1'b1; in_data = 32'h0000_0077;
    step();
    checks++;
    if (tx_valid !== 1'b1 || credits_avail !== 4'd7) begin
      errors++;
      $display("FAIL rst_setup: tx_valid=%b credits=%0d expected 1 7", tx_valid, credits_avail);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || credits_avail !== 4'd8 || link_idle !== 1'b1 || in_ready !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: tx_valid=%b credits=%0d idle=%b in_ready=%b err=%b expected 0 8 1 0 0",
               tx_valid, credits_avail, link_idle, in_ready, err_overflow);
    end
    link_en = 1'b0; in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (tx_valid !== 1'b0 || credits_avail !== 4'd8 || link_idle !== 1'b1 || tx_data !== '0) begin
      errors++;
      $display("FAIL rst_release: tx_valid=%b credits=%0d idle=%b tx_data=%h expected 0 8 1 0",
               tx_valid, credits_avail, link_idle, tx_data);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_zero_credit_return();
    test_send_and_return();
    test_drain();
    test_overflow();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
